// File: rtl/axi4_if.sv
// axi4_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels) with ID pass-through fields.
//   Parameters: A address width, N data bytes (data = N*8 bits), I ID width.
//   Modports: master drives requests (aw/w/ar valid, bready, rready);
//             slave drives ready for requests and the responses (b*, r*).
interface axi4_if #(
    parameter int A = 16,
    parameter int N = 4,
    parameter int I = 1
);
    logic [I-1:0]   awid;
    logic [A-1:0]   awaddr;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready;
    logic [N*8-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic           wvalid;
    logic           wready;
    logic [I-1:0]   bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [I-1:0]   arid;
    logic [A-1:0]   araddr;
    logic [2:0]     arprot;
    logic           arvalid;
    logic           arready;
    logic [I-1:0]   rid;
    logic [N*8-1:0] rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;

    modport master (
        output awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               arid, araddr, arprot, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );

    modport slave (
        input  awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               arid, araddr, arprot, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: 2:1 AXI4-Lite fan-in, two upstream masters share one downstream slave.
//   aclk     clock, rising edge
//   aresetn  synchronous active-low reset
//   axi4_s   [2] slave-side ports facing upstream masters 0 and 1
//   axi4_m   master-side port facing the shared downstream slave
//   Read and write channels arbitrate independently, one outstanding transaction each.
//   The grant is held from address acceptance until the response handshake completes.
//   Define AXI4_LITE_ARBITER_FIXED_PRIORITY_EN to make master 0 always win simultaneous
//   requests (no round-robin pointers); the default is round-robin.
module axi4_lite_arbiter #(
    parameter int A = 16,
    parameter int N = 4,
    parameter int I = 1
) (
    input  logic   aclk,
    input  logic   aresetn,
    axi4_if.slave  axi4_s [2],
    axi4_if.master axi4_m
);
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_B} wr_state_t;

    rd_state_t      rd_st;
    wr_state_t      wr_st;
    logic           rd_g, wr_g, rd_pick, wr_pick, aw_done, w_done;
    logic           ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [1:0]     arv, awv, wv, rrd, brd;
    logic [I-1:0]   arid [2];
    logic [I-1:0]   awid [2];
    logic [A-1:0]   araddr [2];
    logic [A-1:0]   awaddr [2];
    logic [2:0]     arprot [2];
    logic [2:0]     awprot [2];
    logic [N*8-1:0] wdata [2];
    logic [N-1:0]   wstrb [2];

    // Interface arrays only take constant indices, so flatten them here and
    // route back with the grant gating every valid/ready towards upstream.
    for (genvar i = 0; i < 2; i++) begin : g_s
        assign arv[i]    = axi4_s[i].arvalid;
        assign awv[i]    = axi4_s[i].awvalid;
        assign wv[i]     = axi4_s[i].wvalid;
        assign rrd[i]    = axi4_s[i].rready;
        assign brd[i]    = axi4_s[i].bready;
        assign arid[i]   = axi4_s[i].arid;
        assign araddr[i] = axi4_s[i].araddr;
        assign arprot[i] = axi4_s[i].arprot;
        assign awid[i]   = axi4_s[i].awid;
        assign awaddr[i] = axi4_s[i].awaddr;
        assign awprot[i] = axi4_s[i].awprot;
        assign wdata[i]  = axi4_s[i].wdata;
        assign wstrb[i]  = axi4_s[i].wstrb;
        assign axi4_s[i].arready = rd_st == RD_AR && rd_g == 1'(i) && axi4_m.arready;
        assign axi4_s[i].rvalid  = rd_st == RD_R && rd_g == 1'(i) && axi4_m.rvalid;
        assign axi4_s[i].awready = wr_st == WR_ADDR && wr_g == 1'(i) && !aw_done && axi4_m.awready;
        assign axi4_s[i].wready  = wr_st == WR_ADDR && wr_g == 1'(i) && !w_done && axi4_m.wready;
        assign axi4_s[i].bvalid  = wr_st == WR_B && wr_g == 1'(i) && axi4_m.bvalid;
        assign axi4_s[i].rid     = axi4_m.rid;
        assign axi4_s[i].rdata   = axi4_m.rdata;
        assign axi4_s[i].rresp   = axi4_m.rresp;
        assign axi4_s[i].bid     = axi4_m.bid;
        assign axi4_s[i].bresp   = axi4_m.bresp;
    end

    assign axi4_m.arvalid = rd_st == RD_AR && arv[rd_g];
    assign axi4_m.arid    = arid[rd_g];
    assign axi4_m.araddr  = araddr[rd_g];
    assign axi4_m.arprot  = arprot[rd_g];
    assign axi4_m.rready  = rd_st == RD_R && rrd[rd_g];
    // A channel that already handshook in ADDR is masked so it is not accepted twice.
    assign axi4_m.awvalid = wr_st == WR_ADDR && !aw_done && awv[wr_g];
    assign axi4_m.awid    = awid[wr_g];
    assign axi4_m.awaddr  = awaddr[wr_g];
    assign axi4_m.awprot  = awprot[wr_g];
    assign axi4_m.wvalid  = wr_st == WR_ADDR && !w_done && wv[wr_g];
    assign axi4_m.wdata   = wdata[wr_g];
    assign axi4_m.wstrb   = wstrb[wr_g];
    assign axi4_m.bready  = wr_st == WR_B && brd[wr_g];

    assign ar_hs = axi4_m.arvalid && axi4_m.arready;
    assign r_hs  = axi4_m.rvalid && axi4_m.rready;
    assign aw_hs = axi4_m.awvalid && axi4_m.awready;
    assign w_hs  = axi4_m.wvalid && axi4_m.wready;
    assign b_hs  = axi4_m.bvalid && axi4_m.bready;

`ifdef AXI4_LITE_ARBITER_FIXED_PRIORITY_EN
    assign rd_pick = !arv[0];
    assign wr_pick = !awv[0];
`else
    logic rd_ptr, wr_ptr;

    // On contention the master named by the pointer wins; after each completed
    // transaction the pointer moves to the other master.
    assign rd_pick = &arv ? rd_ptr : arv[1];
    assign wr_pick = &awv ? wr_ptr : awv[1];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (r_hs) rd_ptr <= !rd_g;
            if (b_hs) wr_ptr <= !wr_g;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_st <= RD_IDLE;
            rd_g  <= 1'b0;
        end else begin
            case (rd_st)
                RD_IDLE: if (|arv) begin
                    rd_g  <= rd_pick;
                    rd_st <= RD_AR;
                end
                RD_AR:   if (ar_hs) rd_st <= RD_R;
                RD_R:    if (r_hs) rd_st <= RD_IDLE;
                default: rd_st <= RD_IDLE;
            endcase
        end
    end

    // Only awvalid requests a grant; a lone wvalid waits in IDLE.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_st   <= WR_IDLE;
            wr_g    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (wr_st)
                WR_IDLE: if (|awv) begin
                    wr_g  <= wr_pick;
                    wr_st <= WR_ADDR;
                end
                WR_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    wr_st   <= WR_B;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) w_done <= 1'b1;
                end
                WR_B:    if (b_hs) wr_st <= WR_IDLE;
                default: wr_st <= WR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb_axi4_lite_arbiter: scoreboard bench for axi4_lite_arbiter with a small register-file slave.
module tb_axi4_lite_arbiter;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi4_if #(.A(16), .N(4), .I(1)) up [2] ();
    axi4_if #(.A(16), .N(4), .I(1)) dn ();

    axi4_lite_arbiter #(.A(16), .N(4), .I(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi4_s  (up),
        .axi4_m  (dn)
    );

    logic [1:0]  arv = '0, awv = '0, wv = '0, rr = '1, br = '1;
    logic [15:0] ara [2], awa [2];
    logic [31:0] wd [2];
    logic        aid [2], wid [2];
    logic [1:0]  ar_r, aw_r, w_r, r_v, b_v;
    logic [31:0] r_d [2];
    logic [1:0]  r_resp [2], b_resp [2];
    logic        r_id [2], b_id [2];

    for (genvar i = 0; i < 2; i++) begin : g_m
        assign up[i].arvalid = arv[i];
        assign up[i].araddr  = ara[i];
        assign up[i].arid    = aid[i];
        assign up[i].arprot  = 3'd0;
        assign up[i].rready  = rr[i];
        assign up[i].awvalid = awv[i];
        assign up[i].awaddr  = awa[i];
        assign up[i].awid    = wid[i];
        assign up[i].awprot  = 3'd0;
        assign up[i].wvalid  = wv[i];
        assign up[i].wdata   = wd[i];
        assign up[i].wstrb   = 4'hf;
        assign up[i].bready  = br[i];
        assign ar_r[i]   = up[i].arready;
        assign aw_r[i]   = up[i].awready;
        assign w_r[i]    = up[i].wready;
        assign r_v[i]    = up[i].rvalid;
        assign b_v[i]    = up[i].bvalid;
        assign r_d[i]    = up[i].rdata;
        assign r_resp[i] = up[i].rresp;
        assign r_id[i]   = up[i].rid;
        assign b_resp[i] = up[i].bresp;
        assign b_id[i]   = up[i].bid;
    end

    // Downstream register file: 16 words, preset on reset, one outstanding per channel.
    logic [31:0] mem [16];
    logic        aw_got, w_got, bid_l;
    logic [3:0]  wa_l;
    logic [31:0] wd_l;
    assign dn.arready = !dn.rvalid;
    assign dn.awready = !aw_got && !dn.bvalid;
    assign dn.wready  = !w_got && !dn.bvalid;
    assign dn.rresp   = 2'b00;
    assign dn.bresp   = 2'b00;

    always @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < 16; k++) mem[k] <= (k == 1) ? 32'habba_beef : 32'h1000_0000 + 32'(k);
            dn.rvalid <= 1'b0;
            dn.bvalid <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
        end else begin
            if (dn.arvalid && dn.arready) begin
                dn.rvalid <= 1'b1;
                dn.rdata  <= mem[dn.araddr[5:2]];
                dn.rid    <= dn.arid;
            end else if (dn.rvalid && dn.rready) dn.rvalid <= 1'b0;
            if (dn.awvalid && dn.awready) begin
                aw_got <= 1'b1;
                wa_l   <= dn.awaddr[5:2];
                bid_l  <= dn.awid;
            end
            if (dn.wvalid && dn.wready) begin
                w_got <= 1'b1;
                wd_l  <= dn.wdata;
            end
            if ((aw_got || (dn.awvalid && dn.awready)) && (w_got || (dn.wvalid && dn.wready))) begin
                mem[aw_got ? wa_l : dn.awaddr[5:2]] <= w_got ? wd_l : dn.wdata;
                dn.bid    <= aw_got ? bid_l : dn.awid;
                dn.bvalid <= 1'b1;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
            end else if (dn.bvalid && dn.bready) dn.bvalid <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] model [16];
    logic [31:0] exp_r [2][$];
    logic [1:0]  exp_b [2][$];
    logic        exp_arg [$];
    logic        exp_awg [$];
    int          rc [2] = '{0, 0};
    int          r1_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int k = 0; k < 16; k++) model[k] = (k == 1) ? 32'habba_beef : 32'h1000_0000 + 32'(k);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_up0"}, 32'({ar_r[0], aw_r[0], w_r[0], r_v[0], b_v[0]}), 0);
        check({tag, "_up1"}, 32'({ar_r[1], aw_r[1], w_r[1], r_v[1], b_v[1]}), 0);
        check({tag, "_dn"}, 32'({dn.arvalid, dn.awvalid, dn.wvalid, dn.rready, dn.bready}), 0);
    endtask

    // Monitor: pop expectations on upstream response handshakes and downstream grants.
    always @(negedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            if (r_v[i] && rr[i]) begin
                rc[i] <= rc[i] + 1;
                if (exp_r[i].size() == 0) check($sformatf("r_stray%0d", i), 1, 0);
                else check($sformatf("rdata%0d", i), r_d[i], exp_r[i].pop_front());
                check($sformatf("rid%0d", i), 32'(r_id[i]), i);
                check($sformatf("rresp%0d", i), 32'(r_resp[i]), 0);
            end
            if (b_v[i] && br[i]) begin
                if (exp_b[i].size() == 0) check($sformatf("b_stray%0d", i), 1, 0);
                else check($sformatf("bresp%0d", i), 32'(b_resp[i]), 32'(exp_b[i].pop_front()));
                check($sformatf("bid%0d", i), 32'(b_id[i]), i);
            end
        end
        if (r_v[1]) r1_cycles <= r1_cycles + 1;
        if (dn.arvalid && dn.arready && exp_arg.size() > 0) check("ar_grant", 32'(dn.arid), 32'(exp_arg.pop_front()));
        if (dn.awvalid && dn.awready && exp_awg.size() > 0) check("aw_grant", 32'(dn.awid), 32'(exp_awg.pop_front()));
    end

    task automatic rd(input int m, input logic [3:0] w);
        int t;
        exp_r[m].push_back(model[w]);
        ara[m] = {10'd0, w, 2'b00};
        aid[m] = 1'(m);
        arv[m] = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!ar_r[m] && t < 200);
        @(posedge aclk); #1 arv[m] = 1'b0;
        check("ar_wait", 32'(t < 200), 1);
        t = 0;
        do begin @(negedge aclk); t++; end while (!(r_v[m] && rr[m]) && t < 200);
        @(posedge aclk); #1;
        check("r_wait", 32'(t < 200), 1);
    endtask

    task automatic wr(input int m, input logic [3:0] w, input logic [31:0] d, input int early);
        int t;
        logic ad, wdn, a_hs, w_hs;
        exp_b[m].push_back(2'b00);
        awa[m] = {10'd0, w, 2'b00};
        wid[m] = 1'(m);
        wd[m]  = d;
        wv[m]  = 1'b1;
        for (int k = 0; k < early; k++) begin
            @(negedge aclk);
            check("w_early", 32'(dn.wvalid), 0);
        end
        if (early > 0) begin @(posedge aclk); #1; end
        awv[m] = 1'b1;
        ad = 1'b0;
        wdn = 1'b0;
        t = 0;
        while (!(ad && wdn) && t < 200) begin
            @(negedge aclk);
            t++;
            a_hs = awv[m] && aw_r[m];
            w_hs = wv[m] && w_r[m];
            @(posedge aclk); #1;
            if (a_hs) begin awv[m] = 1'b0; ad = 1'b1; end
            if (w_hs) begin wv[m] = 1'b0; wdn = 1'b1; end
        end
        check("aw_w_wait", 32'(t < 200), 1);
        t = 0;
        do begin @(negedge aclk); t++; end while (!b_v[m] && t < 200);
        if (br[m]) begin @(posedge aclk); #1; end
        check("b_wait", 32'(t < 200), 1);
    endtask

    int base0, base1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_init();
        aresetn = 1'b0;
        repeat (4) @(posedge aclk);
        #1 chk_idle("reset");
        aresetn = 1'b1;

        r1_cycles = 0;
        rd(0, 4'd1);
        check("m1_no_rvalid", 32'(r1_cycles), 0);
        check("single_rdata_exp", model[1], 32'habba_beef);

        exp_awg.push_back(1'b0);
        exp_awg.push_back(1'b1);
        fork
            wr(0, 4'd2, 32'h1111_1111, 0);
            wr(1, 4'd2, 32'h2222_2222, 0);
        join
        check("aw_grant_left", 32'(exp_awg.size()), 0);
        model[2] = 32'h2222_2222;
        rd(0, 4'd2);

        wr(1, 4'd3, 32'h3333_3333, 3);
        model[3] = 32'h3333_3333;
        rd(1, 4'd3);

        aresetn = 1'b0;
        @(posedge aclk); #1 aresetn = 1'b1;
        model_init();
        base0 = rc[0];
        base1 = rc[1];
        for (int k = 0; k < 8; k++) begin
            exp_arg.push_back(1'b0);
            exp_arg.push_back(1'b1);
        end
        fork
            for (int k = 0; k < 8; k++) rd(0, 4'(k));
            for (int k = 0; k < 8; k++) rd(1, 4'(k + 8));
        join
        @(negedge aclk);
        check("rr_grants_left", 32'(exp_arg.size()), 0);
        check("rr_count0", 32'(rc[0] - base0), 8);
        check("rr_count1", 32'(rc[1] - base1), 8);

        br[0] = 1'b0;
        wr(0, 4'd5, 32'h5555_5555, 0);
        @(posedge aclk); #1;
        check("in_b_bvalid", 32'(b_v[0]), 1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk_idle("midrst");
        aresetn = 1'b1;
        exp_b[0].delete();
        br[0] = 1'b1;
        model_init();
        rd(0, 4'd5);
        repeat (4) @(negedge aclk);
        check("no_b_replay", 32'(b_v[0]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
